booth_mult_param: RTL and testbench

Parametrised multi-cycle radix-4 Booth multiplier; successor to the fixed 32-bit `mult_32` in the CPU mult-div unit. It multiplies two WIDTH-bit operands in either signed or unsigned mode and returns the full 2×WIDTH-bit product. It also flags when the product overflows WIDTH bits. It sits beside the divider in the execute-stage mult-div unit and uses the same `ctrl_MULT` start, `data_resultRDY` and `data_exception` contract.

---
 rtl/booth_mult_param.sv | 128 ++++++++++++
 tb/tb_booth_mult_param.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/booth_mult_param.sv
// Multi-cycle radix-4 Booth multiplier, signed or unsigned, WIDTH/2 steps per product.
// Full 2*WIDTH-bit result plus an overflow flag for a WIDTH-bit destination.
module booth_mult_param #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_signed,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_result_hi,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             data_busy
);
    localparam int N  = WIDTH / 2;
    localparam int EW = WIDTH + 4;
    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]           state_reg;
    logic [CW-1:0]        count_reg;
    logic signed [EW-1:0] mcand_reg;
    logic [WIDTH-1:0]     mplier_reg;
    logic                 prev_reg;
    logic                 msb_reg;
    logic                 signed_reg;
    logic signed [EW-1:0] acc_hi_reg;
    logic [WIDTH-1:0]     acc_lo_reg;
    logic [WIDTH-1:0]     result_lo_reg;
    logic [WIDTH-1:0]     result_hi_reg;
    logic                 exc_reg;
    logic                 rdy_reg;
    logic                 busy_reg;

    logic [3:0]           ext_bits;
    logic signed [EW-1:0] pp;
    logic signed [EW-1:0] sum;
    logic signed [EW-1:0] acc_hi_next;
    logic [WIDTH-1:0]     acc_lo_next;
    logic [WIDTH-1:0]     hi_next;
    logic                 exc_next;

    // Extension bits above the operand: sign copies in signed mode, zeros otherwise.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ext
            assign ext_bits[gi] = ctrl_signed & multiplicand[WIDTH-1];
        end
    endgenerate

    always_comb begin
        pp = '0;
        case ({mplier_reg[1:0], prev_reg})
            3'b001, 3'b010: pp = mcand_reg;
            3'b011:         pp = mcand_reg <<< 1;
            3'b100:         pp = -(mcand_reg <<< 1);
            3'b101, 3'b110: pp = -mcand_reg;
            default:        pp = '0;
        endcase
        sum         = acc_hi_reg + pp;
        acc_hi_next = sum >>> 2;
        acc_lo_next = {sum[1:0], acc_lo_reg[WIDTH-1:2]};
        // The recoding treats the multiplier as signed WIDTH bits; an unsigned
        // multiplier with its MSB set is worth an extra multiplicand * 2^WIDTH.
        hi_next = acc_hi_next[WIDTH-1:0]
                + ((!signed_reg && msb_reg) ? mcand_reg[WIDTH-1:0] : '0);
        exc_next = signed_reg ? (hi_next != {WIDTH{acc_lo_next[WIDTH-1]}})
                              : (hi_next != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            mcand_reg     <= '0;
            mplier_reg    <= '0;
            prev_reg      <= 1'b0;
            msb_reg       <= 1'b0;
            signed_reg    <= 1'b0;
            acc_hi_reg    <= '0;
            acc_lo_reg    <= '0;
            result_lo_reg <= '0;
            result_hi_reg <= '0;
            exc_reg       <= 1'b0;
            rdy_reg       <= 1'b0;
            busy_reg      <= 1'b0;
        end else if (ctrl_MULT) begin
            state_reg  <= RUN;
            count_reg  <= CW'(N);
            mcand_reg  <= {ext_bits, multiplicand};
            mplier_reg <= multiplier;
            prev_reg   <= 1'b0;
            msb_reg    <= multiplier[WIDTH-1];
            signed_reg <= ctrl_signed;
            acc_hi_reg <= '0;
            acc_lo_reg <= '0;
            exc_reg    <= 1'b0;
            rdy_reg    <= 1'b0;
            busy_reg   <= 1'b1;
        end else if (state_reg == RUN) begin
            acc_hi_reg <= acc_hi_next;
            acc_lo_reg <= acc_lo_next;
            mplier_reg <= mplier_reg >> 2;
            prev_reg   <= mplier_reg[1];
            count_reg  <= count_reg - CW'(1);
            if (count_reg == CW'(1)) begin
                state_reg     <= DONE;
                result_lo_reg <= acc_lo_next;
                result_hi_reg <= hi_next;
                exc_reg       <= exc_next;
                rdy_reg       <= 1'b1;
                busy_reg      <= 1'b0;
            end
        end
    end

    assign data_result    = result_lo_reg;
    assign data_result_hi = result_hi_reg;
    assign data_exception = exc_reg;
    assign data_resultRDY = rdy_reg;
    assign data_busy      = busy_reg;
endmodule

// File: tb/tb_booth_mult_param.sv
// Directed bench for booth_mult_param: 32-bit and 8-bit instances, hand-computed products.
module tb_booth_mult_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        m32_go, m32_s;
    logic [31:0] m32_a, m32_b, m32_lo, m32_hi;
    logic        m32_exc, m32_rdy, m32_busy;
    logic        m8_go, m8_s;
    logic [7:0]  m8_a, m8_b, m8_lo, m8_hi;
    logic        m8_exc, m8_rdy, m8_busy;

    int n_asserts = 0;
    int n_fail    = 0;

    booth_mult_param #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .ctrl_MULT(m32_go), .ctrl_signed(m32_s),
        .multiplicand(m32_a), .multiplier(m32_b),
        .data_result(m32_lo), .data_result_hi(m32_hi), .data_exception(m32_exc),
        .data_resultRDY(m32_rdy), .data_busy(m32_busy)
    );

    booth_mult_param #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .ctrl_MULT(m8_go), .ctrl_signed(m8_s),
        .multiplicand(m8_a), .multiplier(m8_b),
        .data_result(m8_lo), .data_result_hi(m8_hi), .data_exception(m8_exc),
        .data_resultRDY(m8_rdy), .data_busy(m8_busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Called at posedge+1; the next edge is the start edge. Inputs are scrambled afterwards.
    task automatic start32(input logic [31:0] a, input logic [31:0] b, input logic s);
        m32_a = a; m32_b = b; m32_s = s; m32_go = 1'b1;
        @(posedge clk); #1;
        m32_go = 1'b0; m32_a = $urandom; m32_b = $urandom; m32_s = ~s;
    endtask

    task automatic steps32(input string tag, input int n);
        logic bad;
        bad = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            if (m32_rdy !== 1'b0 || m32_busy !== 1'b1) bad = 1'b1;
        end
        check({tag, " busy-window"}, 64'(bad), 64'd0);
    endtask

    task automatic result32(input string tag, input logic [31:0] hi, input logic [31:0] lo,
                            input logic exc);
        @(posedge clk); #1;
        check({tag, " rdy"}, 64'(m32_rdy), 64'd1);
        check({tag, " busy"}, 64'(m32_busy), 64'd0);
        check({tag, " product"}, {m32_hi, m32_lo}, {hi, lo});
        check({tag, " exc"}, 64'(m32_exc), 64'(exc));
        $display("op %s: hi=%h lo=%h exc=%b", tag, m32_hi, m32_lo, m32_exc);
    endtask

    task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] hi, input logic [31:0] lo,
                         input logic exc);
        start32(a, b, s);
        steps32(tag, 15);
        result32(tag, hi, lo, exc);
    endtask

    initial begin
        reset = 1'b1;
        m32_go = 1'b0; m32_s = 1'b0; m32_a = '0; m32_b = '0;
        m8_go = 1'b0; m8_s = 1'b0; m8_a = '0; m8_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset32 product", {m32_hi, m32_lo}, 64'd0);
        check("reset32 flags", {61'd0, m32_exc, m32_rdy, m32_busy}, 64'd0);
        check("reset8 all", {45'd0, m8_hi, m8_lo, m8_exc, m8_rdy, m8_busy}, 64'd0);
        reset = 1'b0;

        run32("5*7", 32'd5, 32'd7, 1'b1, 32'h0, 32'd35, 1'b0);
        run32("10*-3", 32'd10, -32'sd3, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFE2, 1'b0);
        run32("-8*6", -32'sd8, 32'd6, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFD0, 1'b0);
        run32("-12*-5", -32'sd12, -32'sd5, 1'b1, 32'h0, 32'd60, 1'b0);
        run32("min*-1", 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h0, 32'h80000000, 1'b1);
        run32("max*2", 32'h7FFFFFFF, 32'd2, 1'b1, 32'h0, 32'hFFFFFFFE, 1'b1);
        run32("u ffff*ffff", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h1, 1'b1);
        run32("u 65535*2", 32'd65535, 32'd2, 1'b0, 32'h0, 32'd131070, 1'b0);

        // Restart on step 5 of a running operation.
        start32(32'd100, 32'd3, 1'b1);
        steps32("restart first", 4);
        start32(32'd9, 32'd9, 1'b1);
        check("restart after 2nd start", {62'd0, m32_rdy, m32_busy}, 64'd1);
        steps32("restart second", 15);
        result32("restart 9*9", 32'h0, 32'd81, 1'b0);

        // Start on the completion edge wins: RDY never rises for the first op.
        start32(32'd3, 32'd11, 1'b1);
        steps32("start-on-EN first", 15);
        start32(32'd5, 32'd7, 1'b0);
        check("start-on-EN rdy/busy", {62'd0, m32_rdy, m32_busy}, 64'd1);
        steps32("start-on-EN second", 15);
        result32("start-on-EN 5*7", 32'h0, 32'd35, 1'b0);

        // Reset on step 8.
        start32(32'd1234, 32'd5, 1'b1);
        steps32("midreset", 7);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midreset product", {m32_hi, m32_lo}, 64'd0);
        check("midreset flags", {61'd0, m32_exc, m32_rdy, m32_busy}, 64'd0);
        @(posedge clk); #1;
        check("midreset idle", {61'd0, m32_exc, m32_rdy, m32_busy}, 64'd0);
        run32("after reset 6*7", 32'd6, 32'd7, 1'b1, 32'h0, 32'd42, 1'b0);

        // 8-bit instance: (-128)*(-128) = 0x4000.
        m8_a = 8'h80; m8_b = 8'h80; m8_s = 1'b1; m8_go = 1'b1;
        @(posedge clk); #1;
        m8_go = 1'b0; m8_a = 8'h5A; m8_b = 8'hC3; m8_s = 1'b0;
        begin
            logic bad8;
            bad8 = 1'b0;
            repeat (3) begin
                @(posedge clk); #1;
                if (m8_rdy !== 1'b0 || m8_busy !== 1'b1) bad8 = 1'b1;
            end
            check("w8 busy-window", 64'(bad8), 64'd0);
        end
        @(posedge clk); #1;
        check("w8 rdy", {62'd0, m8_rdy, m8_busy}, 64'd2);
        check("w8 product", {48'd0, m8_hi, m8_lo}, 64'h4000);
        check("w8 exc", 64'(m8_exc), 64'd1);
        $display("op w8 -128*-128: hi=%h lo=%h exc=%b", m8_hi, m8_lo, m8_exc);
        repeat (5) @(posedge clk);
        #1;
        check("w8 hold", {46'd0, m8_rdy, m8_exc, m8_hi, m8_lo}, {46'd0, 2'b11, 16'h4000});
        m8_a = 8'd3; m8_b = 8'hFE; m8_s = 1'b1; m8_go = 1'b1;
        @(posedge clk); #1;
        m8_go = 1'b0;
        check("w8 restart rdy", {62'd0, m8_rdy, m8_busy}, 64'd1);
        repeat (4) @(posedge clk);
        #1;
        check("w8 3*-2", {46'd0, m8_rdy, m8_exc, m8_hi, m8_lo}, {46'd0, 2'b10, 16'hFFFA});
        $display("op w8 3*-2: hi=%h lo=%h exc=%b", m8_hi, m8_lo, m8_exc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
